// File: rtl/conv_line_feeder_if.sv
// Stream bus between the pixel/kernel source and conv_line_feeder.
// The i_* group is the incoming sample stream. The o_* group is the column
// stream handed to the 3x3 convolver.
interface conv_line_feeder_if #(
    parameter int BIT_LEN    = 8,
    parameter int MAX_WIDTH  = 640,
    parameter int MAX_HEIGHT = 480
);
    localparam int W_BITS = $clog2(MAX_WIDTH + 1);
    localparam int H_BITS = $clog2(MAX_HEIGHT + 1);

    // sample stream (no backpressure)
    logic [BIT_LEN-1:0] i_data;
    logic               i_valid;
    logic               i_sof;
    logic               i_load_kernel;
    logic [W_BITS-1:0]  i_width;
    logic [H_BITS-1:0]  i_height;

    // column stream towards the convolver
    logic [BIT_LEN-1:0] o_dato0;
    logic [BIT_LEN-1:0] o_dato1;
    logic [BIT_LEN-1:0] o_dato2;
    logic               o_valid;
    logic               o_selecK_I;
    logic               o_frame_done;
    logic               o_error;

    // source side: drives samples, observes columns
    modport master (
        output i_data, i_valid, i_sof, i_load_kernel, i_width, i_height,
        input  o_dato0, o_dato1, o_dato2, o_valid, o_selecK_I, o_frame_done, o_error
    );

    // feeder side: consumes samples, produces columns
    modport slave (
        input  i_data, i_valid, i_sof, i_load_kernel, i_width, i_height,
        output o_dato0, o_dato1, o_dato2, o_valid, o_selecK_I, o_frame_done, o_error
    );
endinterface

// File: rtl/conv_line_feeder.sv
// Line feeder for the 3x3 convolver. It turns a raster pixel stream into
// vertical 3-pixel columns using two row buffers, and turns a column-major
// 9-coefficient kernel stream into 3 kernel columns.
// Pipeline: sample accepted at edge n -> stage-1 registers and line-buffer
// read at edge n -> output registers at edge n+1.
module conv_line_feeder #(
    parameter int BIT_LEN    = 8,
    parameter int MAX_WIDTH  = 640,
    parameter int MAX_HEIGHT = 480
) (
    input  logic               CLK100MHZ,
    input  logic               i_reset,
    conv_line_feeder_if.slave  bus
);
    localparam int W_BITS = $clog2(MAX_WIDTH + 1);
    localparam int H_BITS = $clog2(MAX_HEIGHT + 1);

    typedef enum logic [1:0] {IDLE, KLOAD, FRAME, ERROR} state_t;

    // control state
    state_t             state_q, state_d;
    logic [H_BITS-1:0]  row_q, row_d;
    logic [W_BITS-1:0]  col_q, col_d;
    logic [W_BITS-1:0]  width_q, width_d;
    logic [H_BITS-1:0]  height_q, height_d;
    logic [1:0]         krow_q, krow_d;
    logic [1:0]         kcol_q, kcol_d;
    logic               error_q, error_d;
    logic [BIT_LEN-1:0] kreg_q [3];
    logic [BIT_LEN-1:0] kreg_d [3];

    // stage 1: accepted sample plus pending line-buffer write
    logic               s1_valid_q, s1_valid_d;
    logic               s1_sel_q, s1_sel_d;
    logic               s1_done_q, s1_done_d;
    logic [BIT_LEN-1:0] s1_pix_q, s1_pix_d;
    logic               wr_pend_q, wr_pend_d;
    logic [W_BITS-1:0]  wr_addr_q, wr_addr_d;

    // output registers
    logic [BIT_LEN-1:0] dato_q [3];
    logic [BIT_LEN-1:0] dato_d [3];
    logic               valid_q, valid_d;
    logic               sel_q, sel_d;
    logic               done_q, done_d;

    // Line buffers, one word per column: upper half is row r-1, lower half
    // row r-2. Storing both rows in one word keeps the shift lb0<=lb1 inside
    // a single memory. The write of a pixel is deferred by one cycle so it can
    // use the registered read of the same address (read-first behaviour).
    logic [2*BIT_LEN-1:0] lb_mem [MAX_WIDTH];
    logic [2*BIT_LEN-1:0] lb_rd_data;
    logic                 lb_re;
    logic [W_BITS-1:0]    lb_raddr;

    // combinational helpers
    logic               size_ok;
    logic               sof_go, pix_go, kcoef_go, last_pix;
    logic [H_BITS-1:0]  pix_row, frame_h;
    logic [W_BITS-1:0]  pix_col, frame_w;
    logic [1:0]         coef_row, coef_col;

    assign size_ok = (bus.i_width  >= W_BITS'(3)) && (bus.i_width  <= W_BITS'(MAX_WIDTH)) &&
                     (bus.i_height >= H_BITS'(3)) && (bus.i_height <= H_BITS'(MAX_HEIGHT));

    // Next-state, counters, stage-1 and output-register computation
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        width_d    = width_q;
        height_d   = height_q;
        krow_d     = krow_q;
        kcol_d     = kcol_q;
        error_d    = error_q;
        kreg_d     = kreg_q;
        s1_valid_d = 1'b0;
        s1_sel_d   = s1_sel_q;
        s1_done_d  = 1'b0;
        s1_pix_d   = s1_pix_q;
        wr_pend_d  = 1'b0;
        wr_addr_d  = wr_addr_q;
        lb_re      = 1'b0;
        lb_raddr   = col_q;
        sof_go     = 1'b0;
        pix_go     = 1'b0;
        kcoef_go   = 1'b0;
        last_pix   = 1'b0;
        pix_row    = row_q;
        pix_col    = col_q;
        frame_w    = width_q;
        frame_h    = height_q;
        coef_row   = krow_q;
        coef_col   = kcol_q;

        // classify the incoming sample
        case (state_q)
            IDLE: begin
                if (bus.i_valid && bus.i_load_kernel) begin
                    kcoef_go = 1'b1;
                    coef_row = 2'd0;
                    coef_col = 2'd0;
                end else if (bus.i_valid && bus.i_sof) begin
                    sof_go = 1'b1;
                end
            end
            KLOAD: kcoef_go = bus.i_valid;
            FRAME: begin
                if (bus.i_valid && bus.i_sof) begin
                    sof_go = 1'b1;
                end else begin
                    pix_go = bus.i_valid;
                end
            end
            default: sof_go = bus.i_valid && bus.i_sof;
        endcase

        // start (or restart) of a frame: sample size, then treat as pixel (0,0)
        if (sof_go) begin
            width_d  = bus.i_width;
            height_d = bus.i_height;
            error_d  = !size_ok;
            if (size_ok) begin
                pix_go  = 1'b1;
                pix_row = '0;
                pix_col = '0;
                frame_w = bus.i_width;
                frame_h = bus.i_height;
            end else begin
                state_d = ERROR;
            end
        end

        // image pixel: read both rows at the column, schedule the row shift
        if (pix_go) begin
            lb_re      = 1'b1;
            lb_raddr   = pix_col;
            wr_pend_d  = 1'b1;
            wr_addr_d  = pix_col;
            s1_pix_d   = bus.i_data;
            s1_sel_d   = 1'b1;
            s1_valid_d = (pix_row >= H_BITS'(2));
            last_pix   = (pix_row == frame_h - H_BITS'(1)) && (pix_col == frame_w - W_BITS'(1));
            s1_done_d  = last_pix;
            if (last_pix) begin
                state_d = IDLE;
                row_d   = '0;
                col_d   = '0;
            end else begin
                state_d = FRAME;
                if (pix_col == frame_w - W_BITS'(1)) begin
                    col_d = '0;
                    row_d = pix_row + H_BITS'(1);
                end else begin
                    col_d = pix_col + W_BITS'(1);
                    row_d = pix_row;
                end
            end
        end

        // kernel coefficient: fill the column register, emit on row 2
        if (kcoef_go) begin
            for (int k = 0; k < 3; k++) begin
                if (coef_row == 2'(k)) begin
                    kreg_d[k] = bus.i_data;
                end
            end
            if (coef_row == 2'd2) begin
                s1_valid_d = 1'b1;
                s1_sel_d   = 1'b0;
                krow_d     = 2'd0;
                if (coef_col == 2'd2) begin
                    kcol_d  = 2'd0;
                    state_d = IDLE;
                end else begin
                    kcol_d  = coef_col + 2'd1;
                    state_d = KLOAD;
                end
            end else begin
                krow_d  = coef_row + 2'd1;
                kcol_d  = coef_col;
                state_d = KLOAD;
            end
        end

        // output stage: data holds when no column is presented
        valid_d = s1_valid_q;
        done_d  = s1_done_q;
        sel_d   = sel_q;
        dato_d  = dato_q;
        if (s1_valid_q) begin
            sel_d = s1_sel_q;
            if (s1_sel_q) begin
                dato_d[2] = s1_pix_q;
                dato_d[1] = lb_rd_data[2*BIT_LEN-1:BIT_LEN];
                dato_d[0] = lb_rd_data[BIT_LEN-1:0];
            end else begin
                dato_d = kreg_q;
            end
        end
    end

    // Control and pipeline registers
    always_ff @(posedge CLK100MHZ or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            width_q    <= '0;
            height_q   <= '0;
            krow_q     <= '0;
            kcol_q     <= '0;
            error_q    <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_sel_q   <= 1'b0;
            s1_done_q  <= 1'b0;
            s1_pix_q   <= '0;
            wr_pend_q  <= 1'b0;
            wr_addr_q  <= '0;
            valid_q    <= 1'b0;
            sel_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            width_q    <= width_d;
            height_q   <= height_d;
            krow_q     <= krow_d;
            kcol_q     <= kcol_d;
            error_q    <= error_d;
            s1_valid_q <= s1_valid_d;
            s1_sel_q   <= s1_sel_d;
            s1_done_q  <= s1_done_d;
            s1_pix_q   <= s1_pix_d;
            wr_pend_q  <= wr_pend_d;
            wr_addr_q  <= wr_addr_d;
            valid_q    <= valid_d;
            sel_q      <= sel_d;
            done_q     <= done_d;
        end
    end

    // Per-lane kernel column and output data registers
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            always_ff @(posedge CLK100MHZ or negedge i_reset) begin
                if (!i_reset) begin
                    kreg_q[gi] <= '0;
                    dato_q[gi] <= '0;
                end else begin
                    kreg_q[gi] <= kreg_d[gi];
                    dato_q[gi] <= dato_d[gi];
                end
            end
        end
    endgenerate

    // Line-buffer memory: registered read, deferred write of {pixel, old r-1}
    always_ff @(posedge CLK100MHZ) begin
        if (lb_re) begin
            lb_rd_data <= lb_mem[lb_raddr];
        end
        if (wr_pend_q) begin
            lb_mem[wr_addr_q] <= {s1_pix_q, lb_rd_data[2*BIT_LEN-1:BIT_LEN]};
        end
    end

    assign bus.o_dato0      = dato_q[0];
    assign bus.o_dato1      = dato_q[1];
    assign bus.o_dato2      = dato_q[2];
    assign bus.o_valid      = valid_q;
    assign bus.o_selecK_I   = sel_q;
    assign bus.o_frame_done = done_q;
    assign bus.o_error      = error_q;
endmodule

// File: tb/tb_conv_line_feeder.sv
// Bench for conv_line_feeder: randomized and directed sample streams, a
// behavioural model that predicts each column from the image/kernel contents,
// and a monitor that pops and compares every presented column.
module tb_conv_line_feeder;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_line_feeder_if bus ();
    conv_line_feeder dut (.CLK100MHZ(clk), .i_reset(rst_n), .bus(bus));

    typedef struct {
        logic [7:0] d0, d1, d2;
        logic       sel, done;
        int         tag;
    } exp_t;
    exp_t sb[$];

    localparam int M_IDLE = 0, M_K = 1, M_FRAME = 2, M_ERR = 3;
    int         mstate = M_IDLE;
    int         kcnt = 0, mw = 0, mh = 0, mp = 0;
    logic       merr = 1'b0;
    logic [7:0] kc  [3];
    logic [7:0] img [0:15][0:15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [7:0] d0, d1, d2, input logic sel, done);
        exp_t e;
        e.d0 = d0; e.d1 = d1; e.d2 = d2; e.sel = sel; e.done = done;
        e.tag = cyc + 2;
        sb.push_back(e);
    endtask

    // Model: pixel at linear index p sits at (p / w, p % w); a column exists for rows >= 2
    task automatic model_pix(input logic [7:0] d);
        int r, c;
        r = mp / mw;
        c = mp % mw;
        img[r][c] = d;
        if (r >= 2) push_exp(img[r-2][c], img[r-1][c], d, 1'b1, mp == mw * mh - 1);
        mp++;
        if (mp == mw * mh) mstate = M_IDLE;
    endtask

    task automatic model_sof(input logic [7:0] d, input int w, input int h);
        if (w < 3 || w > 640 || h < 3 || h > 480) begin
            merr = 1'b1;
            mstate = M_ERR;
        end else begin
            merr = 1'b0;
            mw = w; mh = h; mp = 0;
            mstate = M_FRAME;
            model_pix(d);
        end
    endtask

    task automatic model_coef(input logic [7:0] d);
        kc[kcnt % 3] = d;
        kcnt++;
        if (kcnt % 3 == 0) push_exp(kc[0], kc[1], kc[2], 1'b0, 1'b0);
        if (kcnt == 9) mstate = M_IDLE;
    endtask

    task automatic model_sample(input logic sof, input logic lk, input logic [7:0] d, input int w, input int h);
        case (mstate)
            M_IDLE: begin
                if (lk) begin
                    mstate = M_K;
                    kcnt = 0;
                    model_coef(d);
                end else if (sof) begin
                    model_sof(d, w, h);
                end
            end
            M_K:     model_coef(d);
            M_FRAME: if (sof) model_sof(d, w, h); else model_pix(d);
            default: if (sof) model_sof(d, w, h);
        endcase
    endtask

    // One cycle of stimulus; also checks the sticky error flag for everything accepted so far
    task automatic drive(input logic v, input logic sof, input logic lk, input logic [7:0] d, input int w, input int h);
        @(posedge clk);
        #1;
        check("o_error", bus.o_error, merr);
        bus.i_valid       = v;
        bus.i_sof         = sof;
        bus.i_load_kernel = lk;
        bus.i_data        = d;
        bus.i_width       = 10'(w);
        bus.i_height      = 9'(h);
        if (v) model_sample(sof, lk, d, w, h);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 4, 3);
    endtask

    // Sends pixels 0..stop_at-1 (whole frame when stop_at < 0); mode 0 = 16r+c, 1 = random
    task automatic send_frame(input int w, input int h, input int gmin, input int gmax,
                              input int stop_at, input int mode, input bit noise);
        int n;
        logic [7:0] px;
        n = (stop_at < 0) ? w * h : stop_at;
        for (int p = 0; p < n; p++) begin
            idle($urandom_range(gmin, gmax));
            px = (mode == 0) ? 8'(16 * (p / w) + (p % w)) : 8'($urandom);
            drive(1'b1, p == 0, (p != 0) && noise && ($urandom_range(0, 3) == 0), px, w, h);
        end
    endtask

    task automatic send_kernel(input int mode);
        for (int i = 0; i < 9; i++)
            drive(1'b1, 1'($urandom_range(0, 1)), i == 0, (mode == 0) ? 8'(i + 1) : 8'($urandom), 0, 0);
    endtask

    task automatic bad_size(output int w, output int h);
        w = $urandom_range(3, 12);
        h = $urandom_range(3, 8);
        case ($urandom_range(0, 3))
            0: w = $urandom_range(0, 2);
            1: w = $urandom_range(641, 1023);
            2: h = $urandom_range(0, 2);
            default: h = $urandom_range(481, 511);
        endcase
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_dato0"}, bus.o_dato0, 0);
        check({tag, "_dato1"}, bus.o_dato1, 0);
        check({tag, "_dato2"}, bus.o_dato2, 0);
        check({tag, "_valid"}, bus.o_valid, 0);
        check({tag, "_sel"},   bus.o_selecK_I, 0);
        check({tag, "_done"},  bus.o_frame_done, 0);
        check({tag, "_error"}, bus.o_error, 0);
    endtask

    task automatic model_reset();
        mstate = M_IDLE;
        merr = 1'b0;
        kcnt = 0;
        sb.delete();
    endtask

    // Monitor: flag overdue columns, then compare any presented column
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            while (sb.size() > 0 && sb[0].tag < cyc) begin
                e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_column: got none expected d0=%0h d1=%0h d2=%0h by cycle %0d", e.d0, e.d1, e.d2, e.tag);
            end
            if (bus.o_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_column: got d0=%0h d1=%0h d2=%0h sel=%0b expected none",
                             bus.o_dato0, bus.o_dato1, bus.o_dato2, bus.o_selecK_I);
                end else begin
                    e = sb.pop_front();
                    $display("column cyc=%0d d0=%02h d1=%02h d2=%02h sel=%0b done=%0b",
                             cyc, bus.o_dato0, bus.o_dato1, bus.o_dato2, bus.o_selecK_I, bus.o_frame_done);
                    check("col_dato0", bus.o_dato0, e.d0);
                    check("col_dato1", bus.o_dato1, e.d1);
                    check("col_dato2", bus.o_dato2, e.d2);
                    check("col_sel", bus.o_selecK_I, e.sel);
                    check("col_done", bus.o_frame_done, e.done);
                    check("col_latency", cyc, e.tag);
                end
            end else if (bus.o_frame_done) begin
                check("stray_frame_done", bus.o_frame_done, 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish by 500us");
        $fatal(1, "timeout");
    end

    initial begin
        int w, h, stop;
        bus.i_valid = 0; bus.i_sof = 0; bus.i_load_kernel = 0;
        bus.i_data = 0; bus.i_width = 0; bus.i_height = 0;

        // asynchronous reset before any clock edge
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("reset");
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // directed: kernel 1..9, small frame, gapped frame, restart, error
        send_kernel(0);
        idle(3);
        send_frame(4, 3, 0, 0, -1, 0, 1'b0);
        idle(3);
        send_frame(4, 3, 2, 2, -1, 0, 1'b0);
        idle(3);
        send_frame(5, 4, 0, 0, 7, 0, 1'b0);
        send_frame(5, 4, 0, 0, -1, 1, 1'b0);
        idle(3);
        drive(1'b1, 1'b1, 1'b0, 8'h55, 2, 3);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b1, 8'($urandom), 4, 3);
        send_frame(4, 3, 0, 1, -1, 1, 1'b1);
        idle(2);
        drive(1'b1, 1'b0, 1'b0, 8'h77, 4, 3);   // stray sample in IDLE is dropped

        // random mix
        for (int t = 0; t < 30; t++) begin
            w = $urandom_range(3, 12);
            h = $urandom_range(3, 8);
            case ($urandom_range(0, 5))
                0: send_kernel(1);
                1, 2: send_frame(w, h, 0, 2, -1, 1, 1'b1);
                3: begin
                    stop = $urandom_range(1, w * h - 1);
                    send_frame(w, h, 0, 1, stop, 1, 1'b1);
                    send_frame(w, h, 0, 1, -1, 1, 1'b1);
                end
                4: begin
                    send_frame(w, h, 0, 1, $urandom_range(0, w * h - 1), 1, 1'b0);
                    bad_size(w, h);
                    drive(1'b1, 1'b1, 1'b0, 8'($urandom), w, h);
                    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 4, 3);
                    send_frame(5, 3, 0, 1, -1, 1, 1'b0);
                end
                default: idle($urandom_range(1, 4));
            endcase
        end
        idle(4);

        // reset during row 2 of a 4x3 frame, then the small frame again
        send_frame(4, 3, 0, 0, 9, 0, 1'b0);
        #3 rst_n = 1'b0;
        bus.i_valid = 1'b0;
        #1 check_outputs_zero("midreset");
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        send_frame(4, 3, 0, 0, -1, 0, 1'b0);
        idle(5);

        check("leftover_columns", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
